vector_gates_stream: RTL and testbench
======================================

// Module: vector_gates_stream
// PURPOSE
//  Parametrised, streaming successor to the combinational vector-gate block.
//  - Computes per beat: a bitwise op of two WIDTH-bit vectors, a logical (reduction) op, and the inverted concatenation {~b,~a}.
//  - Adds op select, an OR-accumulate mode across beats, and valid/ready handshakes on both sides.
//  - Results are held in a 2-entry output buffer.
//  - Sits between a vector producer and a consumer that may stall.
// PARAMETERS
//  WIDTH   3   operand width in bits (>=1); out_not is 2*WIDTH
// PORTS
//  clk           in   1        sole clock, rising edge
//  rst_n         in   1        reset: one clock; reset is asynchronous and active-low
//  in_valid      in   1        input beat valid
//  in_ready      out  1        block can accept a beat
//  in_a          in   WIDTH    operand a
//  in_b          in   WIDTH    operand b
//  in_op         in   2        0=OR 1=AND 2=XOR 3=OR-accumulate
//  in_last       in   1        ends an accumulate group (used only for op 3)
//  out_valid     out  1        output beat valid
//  out_ready     in   1        consumer accepts beat
//  out_bitwise   out  WIDTH    bitwise result
//  out_logical   out  1        logical result
//  out_not       out  2*WIDTH  {~in_b, ~in_a}
//  out_last      out  1        in_last of this beat, forwarded
// BEHAVIOUR
//  Handshake
//  - Accept when in_valid & in_ready. Pop when out_valid & out_ready.
//  - 2-entry FIFO with count 0..2. in_ready = (count != 2), driven from the registered count only; no combinational path from out_ready.
//  - out_valid = (count != 0). The out_* fields come from the head entry.
//  - Push and pop in the same cycle: count is unchanged and order is preserved.
//  - While out_valid=1 and out_ready=0, the head entry is held stable.
//  Latency and throughput
//  - A beat accepted in cycle N is visible at the output in cycle N+1 if the FIFO was empty.
//  - Throughput is 1 beat/cycle when out_ready is held high.
//  Results per op (computed at accept)
//  - op 0: bitwise = a|b;        logical = (|a)|(|b)
//  - op 1: bitwise = a&b;        logical = (|a)&(|b)
//  - op 2: bitwise = a^b;        logical = (|a)^(|b)
//  - op 3: bitwise = acc|a|b;    logical = |bitwise
//  - out_not = {~b,~a} for every op. Bits [WIDTH-1:0] are ~a.
//  Accumulator (acc, WIDTH bits)
//  - Updates only on an accepted op-3 beat: acc <= in_last ? 0 : (acc|a|b).
//  - Accepted beats with ops 0-2 leave acc unchanged.
//  - Every op-3 beat produces an output beat showing the running value.
//  Reset (async assert, sync release)
//  - Effects: count=0, acc=0, out_valid=0, in_ready=1, and all out_* data=0.
//  - Asserting reset mid-stream discards buffered beats and any partial accumulation, with no output glitch beyond deassertion of out_valid.
//  Boundaries
//  - in_ready is 0 when count==2; an offered beat waits, and the source must hold it stable.
//  - Width logic is zero-extended nowhere: all ops are WIDTH-exact.
// TESTING (WIDTH=3)
//  1. op0, a=101 b=010 -> next cycle: bitwise=111, logical=1, not=101010.
//  2. op1, a=101 b=011 -> bitwise=001, logical=1. op2, a=000 b=000 -> bitwise=000, logical=0.
//  3. op3 beats (001,000), (010,000), (100,000,last) -> outputs 001, 011, 111 with out_last only on the 3rd.
//     Then op3 (000,000) -> 000, confirming acc was cleared.
//  4. out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, 3rd held.
//     Then out_ready=1 -> all 3 drained in order, one per cycle.
//  5. count=2 and acc=011, pull rst_n low mid-cycle -> out_valid=0 at once, in_ready=1.
//     After release, op3 (001,000) -> 001.
//  6. Random ops, out_ready toggling -> scoreboard match vs reference model, no lost or duplicated beats.

Source files
------------

// File: rtl/vector_gates_stream.sv
// Streaming vector-gate unit: per-beat bitwise/logical/inverted results with an OR-accumulate
// mode, buffered in a 2-entry FIFO behind valid/ready handshakes on both sides.

module vgs_lane (
    input  logic       a,
    input  logic       b,
    input  logic       acc,
    input  logic [1:0] op,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        case (op)
            2'd0:    y = a | b;
            2'd1:    y = a & b;
            2'd2:    y = a ^ b;
            default: y = acc | a | b;
        endcase
    end
endmodule

module vector_gates_stream #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_op,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bitwise,
    output logic                 out_logical,
    output logic [2*WIDTH-1:0]   out_not,
    output logic                 out_last
);
    typedef struct packed {
        logic [WIDTH-1:0]   bitwise;
        logic               logical;
        logic [2*WIDTH-1:0] nots;
        logic               last;
    } beat_t;

    beat_t            mem [2];
    beat_t            beat;
    beat_t            head;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] bw;
    logic             accept, pop;

    // Handshake flags come only from the registered count, never from out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        vgs_lane u_lane (
            .a   (in_a[i]),
            .b   (in_b[i]),
            .acc (acc[i]),
            .op  (in_op),
            .y   (bw[i])
        );
    end

    always_comb begin
        beat         = '0;
        beat.bitwise = bw;
        beat.nots    = {~in_b, ~in_a};
        beat.last    = in_last;
        case (in_op)
            2'd0:    beat.logical = (|in_a) | (|in_b);
            2'd1:    beat.logical = (|in_a) & (|in_b);
            2'd2:    beat.logical = (|in_a) ^ (|in_b);
            default: beat.logical = |bw;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            acc    <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= beat;
                wr_ptr      <= ~wr_ptr;
                if (in_op == 2'd3)
                    acc <= in_last ? '0 : (acc | in_a | in_b);
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_bitwise = head.bitwise;
    assign out_logical = head.logical;
    assign out_not     = head.nots;
    assign out_last    = head.last;
endmodule

// File: tb/tb_vector_gates_stream.sv
// Bench for vector_gates_stream (WIDTH=3): directed scenarios plus a queue scoreboard
// fed at accept time and drained whenever the DUT hands a beat to the consumer.

module tb_vector_gates_stream;
    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0]   bw;
        logic           lg;
        logic [2*W-1:0] nt;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [1:0]     in_op = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_bitwise;
    logic           out_logical;
    logic [2*W-1:0] out_not;
    logic           out_last;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [W-1:0] m_acc = '0;
    exp_t e, g;

    vector_gates_stream #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bitwise (out_bitwise),
        .out_logical (out_logical),
        .out_not     (out_not),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so the negedge view is what the next edge samples.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                g = {out_bitwise, out_logical, out_not, out_last};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got bw=%b lg=%b not=%b last=%b, required no beat",
                             out_bitwise, out_logical, out_not, out_last);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL sb_beat: got bw=%b lg=%b not=%b last=%b, required bw=%b lg=%b not=%b last=%b",
                                 out_bitwise, out_logical, out_not, out_last, e.bw, e.lg, e.nt, e.last);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.nt   = {~in_b, ~in_a};
                e.last = in_last;
                case (in_op)
                    2'd0: begin e.bw = in_a | in_b; e.lg = (|in_a) | (|in_b); end
                    2'd1: begin e.bw = in_a & in_b; e.lg = (|in_a) & (|in_b); end
                    2'd2: begin e.bw = in_a ^ in_b; e.lg = (|in_a) ^ (|in_b); end
                    default: begin
                        e.bw  = m_acc | in_a | in_b;
                        e.lg  = |e.bw;
                        m_acc = in_last ? '0 : e.bw;
                    end
                endcase
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic last);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_last = last;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bitwise !== '0 || out_logical !== 1'b0
            || out_not !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b ir=%b bw=%b lg=%b not=%b last=%b, required 0 1 000 0 000000 0",
                     out_valid, in_ready, out_bitwise, out_logical, out_not, out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_ops();
        out_ready = 1'b1;
        send(2'd0, 3'b101, 3'b010, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bitwise !== 3'b111 || out_logical !== 1'b1 || out_not !== 6'b101010) begin
            errors++;
            $display("FAIL op0: got ov=%b bw=%b lg=%b not=%b, required 1 111 1 101010",
                     out_valid, out_bitwise, out_logical, out_not);
        end
        send(2'd1, 3'b101, 3'b011, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bitwise !== 3'b001 || out_logical !== 1'b1) begin
            errors++;
            $display("FAIL op1: got ov=%b bw=%b lg=%b, required 1 001 1", out_valid, out_bitwise, out_logical);
        end
        send(2'd2, 3'b000, 3'b000, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bitwise !== 3'b000 || out_logical !== 1'b0 || out_not !== 6'b111111) begin
            errors++;
            $display("FAIL op2_zero: got ov=%b bw=%b lg=%b not=%b, required 1 000 0 111111",
                     out_valid, out_bitwise, out_logical, out_not);
        end
        send(2'd2, 3'b110, 3'b011, 1'b0);
        checks++;
        if (out_bitwise !== 3'b101 || out_logical !== 1'b0) begin
            errors++;
            $display("FAIL op2: got bw=%b lg=%b, required 101 0", out_bitwise, out_logical);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate();
        logic [W-1:0] a_v [4];
        logic [W-1:0] x_v [4];
        logic         l_v [4];
        a_v = '{3'b001, 3'b010, 3'b100, 3'b000};
        x_v = '{3'b001, 3'b011, 3'b111, 3'b000};
        l_v = '{1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(2'd3, a_v[i], 3'b000, l_v[i]);
            checks++;
            if (out_valid !== 1'b1 || out_bitwise !== x_v[i] || out_last !== l_v[i]
                || out_logical !== (|x_v[i])) begin
                errors++;
                $display("FAIL acc_beat%0d: got ov=%b bw=%b lg=%b last=%b, required 1 %b %b %b",
                         i, out_valid, out_bitwise, out_logical, out_last, x_v[i], |x_v[i], l_v[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(2'd0, 3'b001, 3'b000, 1'b0);
        send(2'd0, 3'b010, 3'b000, 1'b0);
        in_valid = 1'b1; in_op = 2'd0; in_a = 3'b100; in_b = 3'b000; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bitwise !== 3'b001) begin
            errors++;
            $display("FAIL full_hold: got ir=%b ov=%b bw=%b, required 0 1 001", in_ready, out_valid, out_bitwise);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_bitwise !== 3'b010 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain1: got ov=%b bw=%b ir=%b, required 1 010 1", out_valid, out_bitwise, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_bitwise !== 3'b100) begin
            errors++;
            $display("FAIL drain2: got ov=%b bw=%b, required 1 100", out_valid, out_bitwise);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got ov=%b pending=%0d, required 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send(2'd3, 3'b001, 3'b000, 1'b0);
        send(2'd3, 3'b010, 3'b000, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_full: got ir=%b ov=%b, required 0 1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_acc = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bitwise !== '0 || out_not !== '0) begin
            errors++;
            $display("FAIL mid_reset: got ov=%b ir=%b bw=%b not=%b, required 0 1 000 000000",
                     out_valid, in_ready, out_bitwise, out_not);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(2'd3, 3'b001, 3'b000, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bitwise !== 3'b001) begin
            errors++;
            $display("FAIL acc_after_reset: got ov=%b bw=%b, required 1 001", out_valid, out_bitwise);
        end
        send(2'd3, 3'b000, 3'b000, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic took;
        int   n;
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 2'($urandom_range(0, 3));
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_last  = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk); #1;
        if (!took) begin
            n = 0;
            while (!took && n < 20) begin
                out_ready = 1'b1;
                @(negedge clk);
                took = in_valid && in_ready;
                @(posedge clk); #1;
                n++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got ov=%b pending=%0d, required 0 0", out_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_accumulate();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
